// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor (a - b - borrow_in) with start/busy/done handshake
module serial_subtractor #(
   parameter int NUM_BITS = 8
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                start,
   input  logic [NUM_BITS-1:0] a,
   input  logic [NUM_BITS-1:0] b,
   input  logic                borrow_in,
   output logic                busy,
   output logic                done,
   output logic [NUM_BITS-1:0] difference,
   output logic                borrow_out,
   output logic                zero
);

   localparam int CW = $clog2(NUM_BITS + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [NUM_BITS-1:0] a_q, a_d;
   logic [NUM_BITS-1:0] b_q, b_d;
   logic [NUM_BITS-1:0] r_q, r_d;
   logic                br_q, br_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [NUM_BITS-1:0] diff_q, diff_d;
   logic                bout_q, bout_d;
   logic                zero_q, zero_d;

   // Single full-subtractor cell operating on the current LSBs.
   logic                a0, b0, d_bit, br_next, last_bit;
   logic [NUM_BITS-1:0] r_shift;

   assign a0       = a_q[0];
   assign b0       = b_q[0];
   assign d_bit    = a0 ^ b0 ^ br_q;
   assign br_next  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
   assign r_shift  = {d_bit, r_q[NUM_BITS-1:1]};
   assign last_bit = (cnt_q == CW'(NUM_BITS - 1));

   // Next-state logic: operand capture, per-bit shift, and result publication on the final bit.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      zero_d  = zero_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               br_d    = borrow_in;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            a_d   = {1'b0, a_q[NUM_BITS-1:1]};
            b_d   = {1'b0, b_q[NUM_BITS-1:1]};
            r_d   = r_shift;
            br_d  = br_next;
            cnt_d = cnt_q + CW'(1);
            if (last_bit) begin
               diff_d  = r_shift;
               bout_d  = br_next;
               zero_d  = (r_shift == '0);
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         zero_q  <= zero_d;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign difference = diff_q;
   assign borrow_out = bout_q;
   assign zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor
module tb_serial_subtractor;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         n_rst = 1'b0;
   logic         start = 1'b0;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic         borrow_in = 1'b0;
   logic         busy, done, borrow_out, zero;
   logic [N-1:0] difference;

   serial_subtractor #(.NUM_BITS(N)) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .borrow_in  (borrow_in),
      .busy       (busy),
      .done       (done),
      .difference (difference),
      .borrow_out (borrow_out),
      .zero       (zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [N-1:0] diff;
      logic         bout;
      logic         zro;
      int           done_cyc;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on each done and checks output stability in between.
   logic [N-1:0] prev_diff;
   logic         prev_bout, prev_zero, prev_done;
   bit           prev_valid = 0;
   always @(negedge clk) begin
      if (!n_rst) begin
         prev_valid = 0;
         prev_done  = 0;
      end else begin
         if (done) begin
            if (prev_done) check("done_width", 2, 1);
            if (sb.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("difference", difference, e.diff);
               check("borrow_out", borrow_out, e.bout);
               check("zero", zero, e.zro);
               check("done_cycle", cyc, e.done_cyc);
            end
         end else if (prev_valid) begin
            check("stable", {zero, borrow_out, difference}, {prev_zero, prev_bout, prev_diff});
         end
         prev_diff  = difference;
         prev_bout  = borrow_out;
         prev_zero  = zero;
         prev_done  = done;
         prev_valid = 1;
      end
   end

   // Caller is positioned #1 after a rising edge with the DUT idle.
   task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic ibin,
                        input logic [N-1:0] ed, input logic eb);
      exp_t e;
      a = ia; b = ib; borrow_in = ibin; start = 1'b1;
      e.diff = ed; e.bout = eb; e.zro = (ed == '0); e.done_cyc = cyc + 1 + N;
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      a = ~ia; b = ib ^ 8'h5C; borrow_in = ~ibin;
      check("busy_running", busy, 1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40; i++) begin
         if (sb.size() == 0) break;
         @(posedge clk); #1;
      end
      check("completion_timeout", sb.size(), 0);
   endtask

   task automatic op(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic ibin,
                     input logic [N-1:0] ed, input logic eb);
      issue(ia, ib, ibin, ed, eb);
      wait_idle();
      check("busy_idle", busy, 0);
   endtask

   initial begin
      logic [N:0] full;
      logic [N-1:0] ra, rb;
      logic rbin;

      // Reset state
      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_diff", difference, 0);
      check("rst_bout", borrow_out, 0);
      check("rst_zero", zero, 0);
      @(posedge clk); #3;
      n_rst = 1'b1;
      @(posedge clk); #1;

      // Directed vectors
      op(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);
      op(8'h10, 8'h20, 1'b0, 8'hF0, 1'b1);
      op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
      op(8'h42, 8'h41, 1'b1, 8'h00, 1'b0);
      op(8'h05, 8'h01, 1'b0, 8'h04, 1'b0);
      op(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
      op(8'h00, 8'hFF, 1'b0, 8'h01, 1'b1);
      op(8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0);
      op(8'h7F, 8'h80, 1'b1, 8'hFE, 1'b1);

      // Handshake: start held, inputs churn; second accept only at E0+10
      begin
         exp_t e;
         a = 8'hC3; b = 8'h3C; borrow_in = 1'b0; start = 1'b1;
         e.diff = 8'h87; e.bout = 1'b0; e.zro = 1'b0; e.done_cyc = cyc + 1 + N;
         sb.push_back(e);
         for (int i = 0; i < N + 1; i++) begin
            @(posedge clk); #1;
            a = N'($urandom); b = N'($urandom); borrow_in = 1'($urandom);
         end
         @(posedge clk); #1;
         a = 8'h33; b = 8'h11; borrow_in = 1'b1;
         e.diff = 8'h21; e.bout = 1'b0; e.zro = 1'b0; e.done_cyc = cyc + 1 + N;
         sb.push_back(e);
         @(posedge clk); #1;
         start = 1'b0;
         a = 8'hAA; b = 8'hBB; borrow_in = 1'b1;
         wait_idle();
      end

      // Reset mid-operation
      issue(8'h99, 8'h11, 1'b0, 8'h88, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      n_rst = 1'b0;
      #1;
      sb.delete();
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_diff", difference, 0);
      check("midrst_bout", borrow_out, 0);
      check("midrst_zero", zero, 0);
      repeat (3) @(posedge clk);
      #3;
      n_rst = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);

      // Short random regression against an N+1 bit reference
      for (int i = 0; i < 40; i++) begin
         ra = N'($urandom); rb = N'($urandom); rbin = 1'($urandom);
         full = {1'b0, ra} - {1'b0, rb} - {{N{1'b0}}, rbin};
         op(ra, rb, rbin, full[N-1:0], full[N]);
      end

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL global_timeout: simulation did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, LSB-first N-bit subtractor that computes difference = a - b - borrow_in over NUM_BITS clock cycles. It uses a single full-subtractor cell and a registered borrow. It is the subtract-direction counterpart of the team's ripple adder datapath and is used where area matters more than latency. A start/busy/done handshake lets a controlling FSM issue one operation at a time.

## Interface
- NUM_BITS, default 8: operand and result width; legal range 2..32.

- clk  in  1  system clock; all state updates on rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  NUM_BITS  minuend; captured when start is accepted.
- b  in  NUM_BITS  subtrahend; captured when start is accepted.
- borrow_in  in  1  initial borrow; captured when start is accepted.
- busy  out  1  high in SHIFT and DONE states.
- done  out  1  one-cycle pulse when a result becomes valid.
- difference  out  NUM_BITS  registered result, held until the next completion.
- borrow_out  out  1  final borrow (1 means a < b + borrow_in, unsigned).
- zero  out  1  high when difference == 0.

## Operation
- Internal state:
  - Operand shift registers A and B.
  - Result shift register R.
  - Borrow flop br.
  - Bit counter, width ceil(log2(NUM_BITS+1)).
  - FSM with states IDLE, SHIFT, DONE.
- IDLE:
  - If start = 1: load A <- a, B <- b, br <- borrow_in, counter <- 0, and go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one bit per cycle, with a0 = A[0] and b0 = B[0]:
  - d = a0 ^ b0 ^ br.
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - A and B shift right by one. R shifts right with d inserted at the MSB.
  - br <- br_next, counter <- counter + 1.
  - After processing bit NUM_BITS-1, go to DONE.
  - On that same edge, load difference <- {d, R[NUM_BITS-1:1]}, borrow_out <- br_next, and zero <- (that value == 0).
- DONE:
  - done = 1 for exactly this one cycle.
  - Next state is IDLE unconditionally.
- start is ignored in SHIFT and DONE. No queuing: a start held high is accepted on the first IDLE cycle.
- Changes to a, b, or borrow_in after acceptance have no effect on the operation in progress.
- difference, borrow_out, and zero change only at completion. They hold their last value otherwise, including while a new operation runs.
- Arithmetic is unsigned modulo 2^NUM_BITS. borrow_out is the carry-out complement: it is the borrow out of bit NUM_BITS-1.

## Timing
- Reset (n_rst = 0, asynchronous):
  - State goes to IDLE; A, B, R, br, and counter clear to 0.
  - busy = 0, done = 0, difference = 0, borrow_out = 0, zero = 0.
  - Note that zero resets to 0 even though difference = 0.
- Reset asserted mid-operation aborts it. No done is produced, and the outputs take their reset values immediately.
- Latency:
  - start accepted at edge E0.
  - busy is high from E0 through edge E0+NUM_BITS+1.
  - Results are updated and done rises at edge E0+NUM_BITS.
  - done falls at edge E0+NUM_BITS+1, when state returns to IDLE.
- Throughput: the earliest next acceptance is at edge E0+NUM_BITS+2, so one operation per NUM_BITS+2 cycles.
- done and busy are registered: they are decoded from state flops, with no combinational path from inputs.

## Test plan
- **Basic subtract, timing:** NUM_BITS = 8, a = 0x5A, b = 0x23, borrow_in = 0, start pulsed at E0.
  - Required: difference = 0x37, borrow_out = 0, zero = 0.
  - done is high for exactly one cycle, from edge E0+8 to edge E0+9.
- **Borrow cases:**
  - a = 0x10, b = 0x20, borrow_in = 0 -> difference = 0xF0, borrow_out = 1.
  - a = 0x00, b = 0x00, borrow_in = 1 -> difference = 0xFF, borrow_out = 1.
- **Zero flag:** a = 0x42, b = 0x41, borrow_in = 1 -> difference = 0x00, zero = 1, borrow_out = 0. A following 0x05 - 0x01 (borrow_in = 0) clears zero.
- **Handshake rules:**
  - Hold start high and randomize a, b, and borrow_in every cycle during the operation.
  - Required: the result reflects only the values captured at E0. The second operation is accepted at edge E0+10, not earlier.
  - The previous outputs stay stable until the second done.
- **Reset mid-operation:**
  - Assert n_rst low 4 cycles after start -> all outputs are 0 immediately and no done pulse occurs.
  - After release, a new operation with a = 0x80, b = 0x01 gives difference = 0x7F.
- **Random regression:** 10k random (a, b, borrow_in) at NUM_BITS = 8 and NUM_BITS = 16. Check {borrow_out, difference} == (a - b - borrow_in) mod 2^(NUM_BITS+1), with the done cycle count exact.
